fifo_sync: RTL and testbench

//  Single-clock synchronous FIFO; depth 2**ADDR_SIZE words of WORD_SIZE bits.

---
 rtl/fifo_sync_if.sv | 36 +++
 rtl/fifo_sync.sv | 74 +++++++
 tb/tb_fifo_sync.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_if.sv
// Producer/consumer bundle for fifo_sync: write side, read side, mode select and status flags.
// The master drives the requests and the slave (the FIFO) returns data and flags.
interface fifo_sync_if #(
    parameter int WORD_SIZE = 8
);
    // Request semantics: a write takes effect on the edge where we=1 and full=0.
    // A read takes effect on the edge where re=1 and empty=0, and rdata updates on that edge.
    // Requests made against the opposite flag are dropped, never queued.
    logic                 fwft;
    logic                 we;
    logic [WORD_SIZE-1:0] wdata;
    logic                 full;
    logic                 re;
    logic [WORD_SIZE-1:0] rdata;
    logic                 empty;

    modport master (
        output fwft,
        output we,
        output wdata,
        output re,
        input  full,
        input  rdata,
        input  empty
    );

    modport slave (
        input  fwft,
        input  we,
        input  wdata,
        input  re,
        output full,
        output rdata,
        output empty
    );
endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO of 2**ADDR_SIZE words with a registered read port and pointer-derived flags.
// With fwft=1 the write word bypasses to rdata and the stored contents are flushed.
module fifo_sync #(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 8
) (
    input  logic         clk,
    input  logic         rstn,
    fifo_sync_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] PTR_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

    logic [WORD_SIZE-1:0] mem [0:DEPTH-1];

    // The extra MSB on each pointer distinguishes full from empty when the addresses match.
    logic [ADDR_SIZE:0]   pointer_we;
    logic [ADDR_SIZE:0]   pointer_re;
    logic [WORD_SIZE-1:0] rdata_q;

    logic full_c;
    logic empty_c;
    logic do_write;
    logic do_read;

    always_comb begin
        empty_c  = (pointer_we == pointer_re);
        full_c   = (pointer_we[ADDR_SIZE] != pointer_re[ADDR_SIZE]) &&
                   (pointer_we[ADDR_SIZE-1:0] == pointer_re[ADDR_SIZE-1:0]);
        do_write = !bus.fwft && bus.we && !full_c;
        do_read  = !bus.fwft && bus.re && !empty_c;
    end

    assign bus.full  = full_c;
    assign bus.empty = empty_c;
    assign bus.rdata = rdata_q;

    // Storage has no reset so it maps onto a simple dual-port RAM.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[pointer_we[ADDR_SIZE-1:0]] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pointer_we <= '0;
            pointer_re <= '0;
        end else if (bus.fwft) begin
            pointer_we <= '0;
            pointer_re <= '0;
        end else begin
            if (do_write) begin
                pointer_we <= pointer_we + PTR_ONE;
            end
            if (do_read) begin
                pointer_re <= pointer_re + PTR_ONE;
            end
        end
    end

    // A read issued on the same edge as a write to that slot returns the old word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (bus.fwft) begin
            if (bus.we) begin
                rdata_q <= bus.wdata;
            end
        end else if (do_read) begin
            rdata_q <= mem[pointer_re[ADDR_SIZE-1:0]];
        end
    end
endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: reset, fill/drain, simultaneous access at full and empty,
// random traffic against a queue model, and pass-through mode.
module tb_fifo_sync;
    localparam int ADDR_SIZE = 10;
    localparam int WORD_SIZE = 8;
    localparam int DEPTH     = 1 << ADDR_SIZE;

    logic clk;
    logic rstn;

    fifo_sync_if #(.WORD_SIZE(WORD_SIZE)) bus ();

    fifo_sync #(
        .ADDR_SIZE(ADDR_SIZE),
        .WORD_SIZE(WORD_SIZE)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int n_vec;
    int n_err;
    logic [WORD_SIZE-1:0] exp_q[$];
    logic [WORD_SIZE-1:0] last_rd;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.fwft  = 1'b0;
        bus.we    = 1'b0;
        bus.re    = 1'b0;
        bus.wdata = '0;
    endtask

    task automatic check_flags(input string name, input logic exp_empty, input logic exp_full);
        n_vec++;
        if (bus.empty !== exp_empty || bus.full !== exp_full) begin
            n_err++;
            $display("FAIL %s: empty=%b full=%b, required empty=%b full=%b",
                     name, bus.empty, bus.full, exp_empty, exp_full);
        end
    endtask

    task automatic check_rdata(input string name, input logic [WORD_SIZE-1:0] exp);
        n_vec++;
        if (bus.rdata !== exp) begin
            n_err++;
            $display("FAIL %s: rdata=%h, required %h", name, bus.rdata, exp);
        end
    endtask

    task automatic check_ptr(input string name, input logic [ADDR_SIZE:0] exp);
        n_vec++;
        if (dut.pointer_we !== exp) begin
            n_err++;
            $display("FAIL %s: pointer_we=%0d, required %0d", name, dut.pointer_we, exp);
        end
    endtask

    task automatic write_n(input int n);
        logic [WORD_SIZE-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = WORD_SIZE'($urandom_range(0, 255));
            bus.we    = 1'b1;
            bus.wdata = d;
            exp_q.push_back(d);
            tick();
        end
        bus.we = 1'b0;
    endtask

    task automatic read_n(input string name, input int n);
        logic [WORD_SIZE-1:0] e;
        for (int i = 0; i < n; i++) begin
            bus.re = 1'b1;
            tick();
            e = exp_q.pop_front();
            last_rd = e;
            check_rdata(name, e);
        end
        bus.re = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rstn = 1'b1;
        #13;
        rstn = 1'b0;
        #1;
        check_flags("reset_flags", 1'b1, 1'b0);
        check_rdata("reset_rdata", '0);
        #32;
        rstn = 1'b1;
        tick();
        check_flags("reset_after_edge", 1'b1, 1'b0);
        check_ptr("reset_ptr", '0);
    endtask

    task automatic test_fill();
        write_n(DEPTH - 1);
        check_flags("fill_1023", 1'b0, 1'b0);
        write_n(1);
        check_flags("fill_1024", 1'b0, 1'b1);
        check_ptr("fill_ptr", 11'd1024);
        bus.we    = 1'b1;
        bus.wdata = 8'hEE;
        tick();
        bus.we = 1'b0;
        check_ptr("fill_drop_ptr", 11'd1024);
        check_flags("fill_drop_flags", 1'b0, 1'b1);
        read_n("drain_data", DEPTH);
        check_flags("drain_empty", 1'b1, 1'b0);
    endtask

    task automatic test_full_rw();
        logic [WORD_SIZE-1:0] e;
        write_n(DEPTH);
        check_flags("full_rw_pre", 1'b0, 1'b1);
        bus.we    = 1'b1;
        bus.re    = 1'b1;
        bus.wdata = 8'h3C;
        tick();
        idle();
        e = exp_q.pop_front();
        check_rdata("full_rw_oldest", e);
        check_flags("full_rw_flags", 1'b0, 1'b0);
        read_n("full_rw_drain", DEPTH - 2);
        check_flags("full_rw_one_left", 1'b0, 1'b0);
        read_n("full_rw_last", 1);
        check_flags("full_rw_empty", 1'b1, 1'b0);
    endtask

    task automatic test_empty_rw();
        bus.we    = 1'b1;
        bus.re    = 1'b1;
        bus.wdata = 8'h77;
        tick();
        idle();
        check_rdata("empty_rw_hold", last_rd);
        check_flags("empty_rw_flags", 1'b0, 1'b0);
        bus.re = 1'b1;
        tick();
        bus.re = 1'b0;
        check_rdata("empty_rw_read", 8'h77);
        check_flags("empty_rw_after", 1'b1, 1'b0);
    endtask

    task automatic test_random_half();
        logic [WORD_SIZE-1:0] d;
        logic w;
        logic r;
        logic can_w;
        logic can_r;
        logic [WORD_SIZE-1:0] e;
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        exp_q.delete();
        check_rdata("half_reset_rdata", '0);
        write_n(DEPTH / 2);
        check_ptr("half_ptr", 11'd512);
        for (int i = 0; i < 11; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = WORD_SIZE'($urandom_range(0, 255));
            can_w = w && (exp_q.size() < DEPTH);
            can_r = r && (exp_q.size() > 0);
            bus.we    = w;
            bus.re    = r;
            bus.wdata = d;
            tick();
            if (can_r) begin
                e = exp_q.pop_front();
                check_rdata("half_rand_data", e);
            end
            if (can_w) begin
                exp_q.push_back(d);
            end
            check_flags("half_rand_flags", exp_q.size() == 0, exp_q.size() == DEPTH);
        end
        idle();
    endtask

    task automatic test_fwft();
        bus.fwft  = 1'b1;
        bus.we    = 1'b1;
        bus.re    = 1'b1;
        bus.wdata = 8'hA5;
        tick();
        exp_q.delete();
        check_rdata("fwft_bypass", 8'hA5);
        check_flags("fwft_flush", 1'b1, 1'b0);
        check_ptr("fwft_ptr", '0);
        bus.we    = 1'b0;
        bus.wdata = 8'h11;
        tick();
        check_rdata("fwft_hold", 8'hA5);
        idle();
        tick();
        check_flags("fwft_off_empty", 1'b1, 1'b0);
        bus.we    = 1'b1;
        bus.wdata = 8'h5A;
        tick();
        bus.we = 1'b0;
        check_flags("fwft_post_write", 1'b0, 1'b0);
        bus.re = 1'b1;
        tick();
        bus.re = 1'b0;
        check_rdata("fwft_post_read", 8'h5A);
        check_flags("fwft_post_empty", 1'b1, 1'b0);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        last_rd = '0;
        test_reset();
        test_fill();
        test_full_rw();
        test_empty_rw();
        test_random_half();
        test_fwft();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
